// File: rtl/cambus_fifo_pkg.sv
// ============================================================================
// Module : cambus_pkg
// Brief  : Shared widths, field indices and Gray-code helpers for cambus_fifo.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

package cambus_pkg;

    localparam int CAMBUS_DATA_W = 14;
    localparam int CAMBUS_ADDR_W = 4;

    // Word layout: {hsync, vsync, pixel[11:0]}
    localparam int HSYNC_BIT = 13;
    localparam int VSYNC_BIT = 12;

    // Operate on a 32-bit container; callers zero-extend and cast back to pointer width.
    function automatic logic [31:0] bin2gray(input logic [31:0] b);
        return b ^ (b >> 1);
    endfunction

    function automatic logic [31:0] gray2bin(input logic [31:0] g);
        logic [31:0] b;
        b[31] = g[31];
        for (int i = 30; i >= 0; i--) begin
            b[i] = b[i+1] ^ g[i];
        end
        return b;
    endfunction

endpackage

`default_nettype wire

// File: rtl/cambus_fifo_cdc_sync2.sv
// ============================================================================
// Module : cdc_sync2
// Brief  : Parametric-width two-flop synchronizer (no reset on the sync chain).
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module cdc_sync2 #(
    parameter int WIDTH = 1
) (
    input  logic             clk,
    input  logic [WIDTH-1:0] d,
    output logic [WIDTH-1:0] q
);

    logic [WIDTH-1:0] r_meta;
    logic [WIDTH-1:0] r_sync;

    always_ff @(posedge clk) begin
        r_meta <= d;
        r_sync <= r_meta;
    end

    assign q = r_sync;

endmodule

`default_nettype wire

// File: rtl/cambus_fifo.sv
// ============================================================================
// Module : cambus_fifo
// Brief  : Dual-clock FIFO from camera pixel clock (wrclk) to system clock (clk).
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module cambus_fifo
    import cambus_pkg::*;
#(
    parameter int DATA_W = CAMBUS_DATA_W,
    parameter int ADDR_W = CAMBUS_ADDR_W
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              wrclk,
    input  logic              wrreq,
    input  logic [DATA_W-1:0] data,
    output logic              wrfull,
    input  logic              rdreq,
    output logic              rdempty,
    output logic [DATA_W-1:0] q
);

    localparam int c_ptr_w = ADDR_W + 1;
    localparam int c_depth = 2 ** ADDR_W;

    logic [DATA_W-1:0]  r_mem [c_depth];

    // Write domain (wrclk)
    logic               w_wr_rst_n;
    logic               w_wr_en;
    logic               r_wrfull;
    logic [c_ptr_w-1:0] r_wbin;
    logic [c_ptr_w-1:0] r_wgray;
    logic [c_ptr_w-1:0] w_wbin_next;
    logic [c_ptr_w-1:0] w_wgray_next;
    logic [c_ptr_w-1:0] w_rgray_sync;
    logic [c_ptr_w-1:0] w_full_gray;

    // Read domain (clk)
    logic               w_rd_en;
    logic               r_rdempty;
    logic [DATA_W-1:0]  r_q;
    logic [c_ptr_w-1:0] r_rbin;
    logic [c_ptr_w-1:0] r_rgray;
    logic [c_ptr_w-1:0] w_rbin_next;
    logic [c_ptr_w-1:0] w_rgray_next;
    logic [c_ptr_w-1:0] w_wgray_sync;

    // rst must stay low for at least two wrclk periods plus two clk periods so both
    // pointer images settle to zero before either side leaves reset.
    cdc_sync2 #(.WIDTH(1)) u_rst_sync (
        .clk (wrclk),
        .d   (rst),
        .q   (w_wr_rst_n)
    );

    cdc_sync2 #(.WIDTH(c_ptr_w)) u_rptr_sync (
        .clk (wrclk),
        .d   (r_rgray),
        .q   (w_rgray_sync)
    );

    cdc_sync2 #(.WIDTH(c_ptr_w)) u_wptr_sync (
        .clk (clk),
        .d   (r_wgray),
        .q   (w_wgray_sync)
    );

    assign w_wr_en      = wrreq & ~r_wrfull;
    assign w_wbin_next  = r_wbin + c_ptr_w'(w_wr_en);
    assign w_wgray_next = c_ptr_w'(bin2gray(32'(w_wbin_next)));
    // Full when write pointer is one lap ahead: top two Gray bits differ, rest equal.
    assign w_full_gray  = {~w_rgray_sync[c_ptr_w-1 -: 2], w_rgray_sync[c_ptr_w-3:0]};

    always_ff @(posedge wrclk) begin
        if (!w_wr_rst_n) begin
            r_wbin   <= '0;
            r_wgray  <= '0;
            r_wrfull <= 1'b1;
        end else begin
            r_wbin   <= w_wbin_next;
            r_wgray  <= w_wgray_next;
            r_wrfull <= (w_wgray_next == w_full_gray);
        end
    end

    always_ff @(posedge wrclk) begin
        if (w_wr_en) begin
            r_mem[r_wbin[ADDR_W-1:0]] <= data;
        end
    end

    assign w_rd_en      = rdreq & ~r_rdempty;
    assign w_rbin_next  = r_rbin + c_ptr_w'(w_rd_en);
    assign w_rgray_next = c_ptr_w'(bin2gray(32'(w_rbin_next)));

    always_ff @(posedge clk) begin
        if (!rst) begin
            r_rbin    <= '0;
            r_rgray   <= '0;
            r_rdempty <= 1'b1;
            r_q       <= '0;
        end else begin
            r_rbin    <= w_rbin_next;
            r_rgray   <= w_rgray_next;
            r_rdempty <= (w_rgray_next == w_wgray_sync);
            if (w_rd_en) begin
                r_q <= r_mem[r_rbin[ADDR_W-1:0]];
            end
        end
    end

    assign wrfull  = r_wrfull;
    assign rdempty = r_rdempty;
    assign q       = r_q;

endmodule

`default_nettype wire

// File: tb/tb_cambus_fifo.sv
// Scoreboard bench for cambus_fifo: accepted writes are queued, a clk-side monitor
// pops and compares on every accepted read.
`timescale 1ns/1ps
`default_nettype none

module tb_cambus_fifo;
    import cambus_pkg::*;

    localparam int DW = CAMBUS_DATA_W;

    logic          clk   = 1'b0;
    logic          wrclk = 1'b0;
    logic          rst   = 1'b0;
    logic          wrreq = 1'b0;
    logic          rdreq = 1'b0;
    logic [DW-1:0] data  = '0;
    logic          wrfull;
    logic          rdempty;
    logic [DW-1:0] q;

    realtime clk_hp = 5.0;
    realtime wr_hp  = 20.0;

    int n_checks = 0;
    int n_fail   = 0;
    int n_pops   = 0;
    logic [DW-1:0] sb[$];

    always #(clk_hp) clk = ~clk;
    initial begin
        #3;
        forever #(wr_hp) wrclk = ~wrclk;
    end

    cambus_fifo dut (
        .clk     (clk),
        .rst     (rst),
        .wrclk   (wrclk),
        .wrreq   (wrreq),
        .data    (data),
        .wrfull  (wrfull),
        .rdreq   (rdreq),
        .rdempty (rdempty),
        .q       (q)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Expected-data producer: every write the FIFO accepts.
    always @(posedge wrclk) begin
        if (rst && wrreq && wrfull === 1'b0) sb.push_back(data);
    end

    // Monitor: compares q one cycle after each accepted read; holds q on underflow.
    initial begin
        logic          acc;
        logic          und;
        logic [DW-1:0] q_prev;
        logic [DW-1:0] exp_v;
        forever begin
            @(posedge clk);
            acc    = rst && rdreq && (rdempty === 1'b0);
            und    = rst && rdreq && (rdempty === 1'b1);
            q_prev = q;
            #1;
            if (acc) begin
                n_pops++;
                if (sb.size() == 0) begin
                    n_checks++;
                    n_fail++;
                    $display("FAIL rd_unexpected: got 0x%0h, expected no data at %0t", q, $time);
                end else begin
                    exp_v = sb.pop_front();
                    check("rd_data", 32'(q), 32'(exp_v));
                end
            end else if (und) begin
                check("underflow_hold", 32'(q), 32'(q_prev));
            end
        end
    end

    initial begin
        #500us;
        $display("FAIL watchdog: simulation did not finish, expected completion");
        $fatal(1);
    end

    task automatic do_reset(input int hold);
        int k;
        @(negedge clk) rst = 1'b0;
        repeat (3) @(negedge clk);
        check("rst_rdempty", 32'(rdempty), 32'd1);
        check("rst_q", 32'(q), 32'd0);
        repeat (hold - 3) @(negedge clk);
        check("rst_wrfull", 32'(wrfull), 32'd1);
        sb.delete();
        @(negedge clk) rst = 1'b1;
        k = 0;
        while (k < 3 && wrfull !== 1'b0) begin
            @(posedge wrclk);
            #0.5;
            k++;
        end
        check("rst_wrfull_release", 32'(wrfull), 32'd0);
    endtask

    task automatic write_seq(input logic [DW-1:0] vals[$], input bit retry, input int idle_pct);
        foreach (vals[i]) begin
            int  tries = 0;
            bit  done  = 1'b0;
            while (!done) begin
                @(negedge wrclk);
                tries++;
                if (tries > 1000) begin
                    n_checks++;
                    n_fail++;
                    $display("FAIL write_timeout: word 0x%0h not accepted, expected acceptance", vals[i]);
                    done = 1'b1;
                end else if (idle_pct > 0 && $urandom_range(0, 99) < idle_pct) begin
                    wrreq = 1'b0;
                end else begin
                    wrreq = 1'b1;
                    data  = vals[i];
                    @(posedge wrclk);
                    done = (wrfull === 1'b0) || !retry;
                end
            end
        end
        @(negedge wrclk) wrreq = 1'b0;
    endtask

    task automatic drain(input int bound);
        int k = 0;
        @(negedge clk) rdreq = 1'b1;
        while (sb.size() != 0 && k < bound) begin
            @(negedge clk);
            k++;
        end
        check("drain_left", 32'(sb.size()), 32'd0);
        check("drain_rdempty", 32'(rdempty), 32'd1);
        rdreq = 1'b0;
    endtask

    task automatic ratio_run(input realtime new_wr_hp, input int nwords);
        logic [DW-1:0] vals[$];
        bit wr_done = 1'b0;
        int p0 = n_pops;
        wr_hp = new_wr_hp;
        for (int i = 0; i < nwords; i++) vals.push_back(DW'($urandom_range(0, 16383)));
        fork
            begin
                write_seq(vals, 1'b1, 30);
                wr_done = 1'b1;
            end
            begin
                int k = 0;
                while (!(wr_done && sb.size() == 0) && k < 20000) begin
                    @(negedge clk);
                    rdreq = ($urandom_range(0, 99) < 50);
                    k++;
                end
                @(negedge clk) rdreq = 1'b0;
            end
        join
        check("ratio_count", 32'(n_pops - p0), 32'(nwords));
        check("ratio_left", 32'(sb.size()), 32'd0);
        repeat (4) @(negedge clk);
        check("ratio_rdempty", 32'(rdempty), 32'd1);
    endtask

    initial begin
        logic [DW-1:0] vals[$];
        int p0;

        // Power-on reset, 25 MHz write / 100 MHz read.
        do_reset(20);

        // Ordering: 0x0001..0x0040 streamed, reader always requesting.
        vals.delete();
        for (int i = 1; i <= 64; i++) vals.push_back(DW'(i));
        p0 = n_pops;
        fork
            write_seq(vals, 1'b1, 0);
            @(negedge clk) rdreq = 1'b1;
        join
        drain(200);
        check("order_count", 32'(n_pops - p0), 32'd64);

        // Fill: 20 writes, no reads; only the first 16 stick.
        vals.delete();
        for (int i = 1; i <= 20; i++) vals.push_back(DW'(i));
        write_seq(vals, 1'b0, 0);
        check("fill_wrfull", 32'(wrfull), 32'd1);
        check("fill_count", 32'(sb.size()), 32'd16);
        check("fill_first", 32'(sb[0]), 32'd1);
        check("fill_last", 32'(sb[sb.size()-1]), 32'd16);
        p0 = n_pops;
        drain(200);
        check("fill_read_count", 32'(n_pops - p0), 32'd16);
        repeat (4) @(posedge wrclk);
        #0.5;
        check("fill_wrfull_clear", 32'(wrfull), 32'd0);

        // Underflow: read held while empty, then one new word.
        @(negedge clk) rdreq = 1'b1;
        repeat (10) @(negedge clk);
        vals.delete();
        vals.push_back(14'h0155);
        p0 = n_pops;
        write_seq(vals, 1'b1, 0);
        drain(100);
        check("underflow_next_count", 32'(n_pops - p0), 32'd1);
        check("underflow_q", 32'(q), 32'h0155);

        // Mid-operation reset with 10 words queued.
        vals.delete();
        for (int i = 0; i < 10; i++) vals.push_back(DW'(14'h0100 + i));
        write_seq(vals, 1'b1, 0);
        repeat (10) @(negedge clk);
        check("midrst_pre_rdempty", 32'(rdempty), 32'd0);
        do_reset(20);
        vals.delete();
        vals.push_back(14'h3ABC);
        vals.push_back(14'h0123);
        p0 = n_pops;
        write_seq(vals, 1'b1, 0);
        drain(100);
        check("midrst_count", 32'(n_pops - p0), 32'd2);
        check("midrst_last_q", 32'(q), 32'h0123);

        // Clock ratios with drifting phase: ~1:1, 4:1 and 1:3 (clk:wrclk frequency).
        ratio_run(5.13, 60);
        ratio_run(20.7, 40);
        ratio_run(1.71, 80);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

`default_nettype wire
